// File: rtl/symmetric_tap_reader_pkg.sv
// Shared constants and types for the serial symmetric FIR datapath:
// filter geometry, sample/pair-sum types and the tap-reader state encoding.
package fir_pkg;

    localparam int unsigned TAPS  = 33;
    localparam int unsigned DW    = 3;
    localparam int unsigned PAIRS = (TAPS - 1) / 2;
    localparam int unsigned AW    = 6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic signed [DW-1:0] sample_t;
    typedef logic signed [DW:0]   pairsum_t;

endpackage

// File: rtl/symmetric_tap_reader_if.sv
// Sample-side inputs and tap-stream outputs of the symmetric tap reader.
// master: sampler / MAC side, slave: the tap reader itself.
interface symmetric_tap_reader_if #(
    parameter int unsigned DW = fir_pkg::DW,
    parameter int unsigned AW = fir_pkg::AW
) ();

    logic          iEnSample_600k;
    logic          iEnDelay;
    logic [DW-1:0] iFirIn;

    logic [AW-1:0] oTapIdx;
    logic [DW:0]   oPairSum;
    logic          oCenter;
    logic          oValid;
    logic          oLast;
    logic          oBusy;
    logic          oOverrun;

    modport master (
        output iEnSample_600k, iEnDelay, iFirIn,
        input  oTapIdx, oPairSum, oCenter, oValid, oLast, oBusy, oOverrun
    );

    modport slave (
        input  iEnSample_600k, iEnDelay, iFirIn,
        output oTapIdx, oPairSum, oCenter, oValid, oLast, oBusy, oOverrun
    );

endinterface

// File: rtl/symmetric_tap_reader_ring.sv
// Sample history register file: DEPTH x DW entries, asynchronous clear,
// one synchronous write port and two combinational read ports.
module sample_ring_mem #(
    parameter int unsigned DEPTH = fir_pkg::TAPS,
    parameter int unsigned DW    = fir_pkg::DW,
    parameter int unsigned AW    = fir_pkg::AW
) (
    input  logic          iClk_12M,
    input  logic          iRsn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] rd_a_addr,
    input  logic [AW-1:0] rd_b_addr,
    output logic [DW-1:0] rd_a_data,
    output logic [DW-1:0] rd_b_data
);

    logic [DW-1:0] mem [DEPTH];

    // Storage: clear every entry on reset, otherwise write one sample when enabled.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd_a_data = mem[rd_a_addr];
    assign rd_b_data = mem[rd_b_addr];

endmodule

// File: rtl/symmetric_tap_reader.sv
// Serial read side of the FIR sample history. Each accepted sample is written
// into a TAPS-entry ring, then the symmetric pair sums x[n-k] + x[n-(TAPS-1)+k]
// for k = 0..PAIRS-1 followed by the centre tap are streamed one per clock.
module symmetric_tap_reader #(
    parameter int unsigned TAPS = fir_pkg::TAPS,
    parameter int unsigned DW   = fir_pkg::DW,
    parameter int unsigned AW   = fir_pkg::AW
) (
    input  logic                         iClk_12M,
    input  logic                         iRsn,
    symmetric_tap_reader_if.slave        bus
);

    import fir_pkg::*;

    localparam int unsigned   PAIRS_N  = (TAPS - 1) / 2;
    localparam logic [AW-1:0] LAST_PTR = AW'(TAPS - 1);
    localparam logic [AW-1:0] CENTER_K = AW'(PAIRS_N);

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
        return (p == '0) ? LAST_PTR : p - 1'b1;
    endfunction

    state_t        state_q, state_d;
    logic [AW-1:0] k_q, k_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rd_a_q, rd_a_d;
    logic [AW-1:0] rd_b_q, rd_b_d;

    logic          accept;
    logic          beat_valid;
    logic          beat_last;
    logic          overrun_set;

    logic [DW-1:0] ring_a, ring_b;
    logic [DW:0]   ext_a, ext_b, pair_sum;

    logic [AW-1:0] tap_idx_q;
    logic [DW:0]   pair_sum_q;
    logic          center_q;
    logic          valid_q;
    logic          last_q;
    logic          overrun_q;

    assign accept = bus.iEnSample_600k & bus.iEnDelay;

    sample_ring_mem #(
        .DEPTH (TAPS),
        .DW    (DW),
        .AW    (AW)
    ) u_ring (
        .iClk_12M  (iClk_12M),
        .iRsn      (iRsn),
        .we        (accept),
        .waddr     (wptr_d),
        .wdata     (bus.iFirIn),
        .rd_a_addr (rd_a_q),
        .rd_b_addr (rd_b_q),
        .rd_a_data (ring_a),
        .rd_b_data (ring_b)
    );

    // Exact signed pair sum; on the centre beat both pointers meet and only rdA counts.
    assign ext_a    = {ring_a[DW-1], ring_a};
    assign ext_b    = {ring_b[DW-1], ring_b};
    assign pair_sum = beat_last ? ext_a : ext_a + ext_b;

    // Next-state: beat sequencing in RUN; an accept always wins and restarts at k = 0.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        wptr_d      = wptr_q;
        rd_a_d      = rd_a_q;
        rd_b_d      = rd_b_q;
        beat_valid  = 1'b0;
        beat_last   = 1'b0;
        overrun_set = 1'b0;

        if (state_q == RUN) begin
            beat_valid = 1'b1;
            beat_last  = (k_q == CENTER_K);
            rd_a_d     = ptr_dec(rd_a_q);
            rd_b_d     = ptr_inc(rd_b_q);
            if (beat_last) begin
                state_d = IDLE;
            end else begin
                k_d = k_q + 1'b1;
            end
        end

        // The ring is written through wptr_d, so the first beat already reads the new sample.
        if (accept) begin
            wptr_d      = ptr_inc(wptr_q);
            state_d     = RUN;
            k_d         = '0;
            rd_a_d      = wptr_d;
            rd_b_d      = ptr_inc(wptr_d);
            overrun_set = (state_q == RUN) && !beat_last;
        end
    end

    // State, beat counter and ring pointers.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q <= IDLE;
            k_q     <= '0;
            wptr_q  <= '0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            wptr_q  <= wptr_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
        end
    end

    // Output registers: index and sum hold between sequences, overrun is sticky.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            tap_idx_q  <= '0;
            pair_sum_q <= '0;
            center_q   <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            valid_q  <= beat_valid;
            last_q   <= beat_last;
            center_q <= beat_last;
            if (beat_valid) begin
                tap_idx_q  <= k_q;
                pair_sum_q <= pair_sum;
            end
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.oTapIdx  = tap_idx_q;
    assign bus.oPairSum = pair_sum_q;
    assign bus.oCenter  = center_q;
    assign bus.oValid   = valid_q;
    assign bus.oLast    = last_q;
    assign bus.oBusy    = (state_q == RUN);
    assign bus.oOverrun = overrun_q;

endmodule

// File: tb/tb_symmetric_tap_reader.sv
// Directed bench for symmetric_tap_reader: impulse, ramp, pointer wrap,
// gated strobes, overrun and mid-sequence reset.
module tb_symmetric_tap_reader;

    import fir_pkg::*;

    logic        iClk_12M = 1'b0;
    logic        iRsn;
    int          total = 0;
    int          bad   = 0;
    int unsigned n_acc = 0;
    sample_t     hist [TAPS];

    symmetric_tap_reader_if bus ();

    symmetric_tap_reader dut (
        .iClk_12M (iClk_12M),
        .iRsn     (iRsn),
        .bus      (bus)
    );

    always #21 iClk_12M = ~iClk_12M;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge iClk_12M);
        #1;
    endtask

    task automatic model_clear();
        for (int j = 0; j < int'(TAPS); j++) hist[j] = '0;
        n_acc = 0;
    endtask

    task automatic model_push(input sample_t s);
        for (int j = int'(TAPS) - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = s;
        n_acc++;
    endtask

    function automatic pairsum_t model_sum(input int k);
        if (k == int'(PAIRS)) return pairsum_t'(hist[k]);
        return pairsum_t'(hist[k]) + pairsum_t'(hist[int'(TAPS) - 1 - k]);
    endfunction

    task automatic drive_accept(input sample_t s);
        bus.iFirIn         = s;
        bus.iEnDelay       = 1'b1;
        bus.iEnSample_600k = 1'b1;
        step();
        bus.iEnSample_600k = 1'b0;
        model_push(s);
    endtask

    task automatic test_reset();
        iRsn               = 1'b0;
        bus.iEnSample_600k = 1'b0;
        bus.iEnDelay       = 1'b0;
        bus.iFirIn         = '0;
        model_clear();
        repeat (3) step();
        total++;
        if ({bus.oValid, bus.oLast, bus.oCenter, bus.oBusy, bus.oOverrun, bus.oTapIdx, bus.oPairSum} !== 15'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {bus.oValid, bus.oLast, bus.oCenter, bus.oBusy, bus.oOverrun, bus.oTapIdx, bus.oPairSum});
        end
        total++;
        if (dut.wptr_q !== '0) begin
            bad++;
            $display("FAIL reset_wptr: got %0d want 0", dut.wptr_q);
        end
        iRsn = 1'b1;
        repeat (2) step();
        total++;
        if (bus.oValid !== 1'b0 || bus.oBusy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_idle: valid=%b busy=%b want 0 0", bus.oValid, bus.oBusy);
        end
    endtask

    // Hand-derived: after the s-th sample (0-based) the impulse sits at x[n-s].
    task automatic test_impulse();
        pairsum_t exp;
        for (int s = 0; s < int'(TAPS); s++) begin
            drive_accept((s == 0) ? sample_t'(1) : sample_t'(0));
            for (int k = 0; k <= int'(PAIRS); k++) begin
                step();
                exp = (k == s || (k != int'(PAIRS) && int'(TAPS) - 1 - k == s)) ? pairsum_t'(1) : pairsum_t'(0);
                total++;
                if (bus.oValid !== 1'b1 || bus.oTapIdx !== AW'(k) || bus.oPairSum !== exp ||
                    bus.oCenter !== (k == int'(PAIRS)) || bus.oLast !== (k == int'(PAIRS))) begin
                    bad++;
                    $display("FAIL impulse s=%0d k=%0d: valid=%b idx=%0d sum=%0d ctr=%b last=%b want sum=%0d",
                             s, k, bus.oValid, bus.oTapIdx, $signed(bus.oPairSum), bus.oCenter, bus.oLast, exp);
                end
            end
            step();
            total++;
            if (bus.oValid !== 1'b0 || bus.oLast !== 1'b0 || bus.oCenter !== 1'b0 ||
                bus.oBusy !== 1'b0 || bus.oTapIdx !== AW'(PAIRS)) begin
                bad++;
                $display("FAIL impulse_idle s=%0d: valid=%b last=%b ctr=%b busy=%b idx=%0d want 0 0 0 0 16",
                         s, bus.oValid, bus.oLast, bus.oCenter, bus.oBusy, bus.oTapIdx);
            end
            step();
        end
    endtask

    task automatic test_ramp();
        pairsum_t exp;
        for (int i = 0; i < int'(TAPS); i++) begin
            drive_accept(sample_t'(i + 1));
            for (int k = 0; k <= int'(PAIRS); k++) begin
                step();
                exp = model_sum(k);
                total++;
                if (bus.oValid !== 1'b1 || bus.oTapIdx !== AW'(k) || bus.oPairSum !== exp ||
                    bus.oCenter !== (k == int'(PAIRS))) begin
                    bad++;
                    $display("FAIL ramp i=%0d k=%0d: valid=%b idx=%0d sum=%0d ctr=%b want sum=%0d",
                             i, k, bus.oValid, bus.oTapIdx, $signed(bus.oPairSum), bus.oCenter, exp);
                end
                // x[11] = x[3] = -4 meet on pair 12 after the 24th sample
                if (i == 23 && k == 12) begin
                    total++;
                    if (bus.oPairSum !== 4'b1000) begin
                        bad++;
                        $display("FAIL ramp_min: got %0d want -8", $signed(bus.oPairSum));
                    end
                end
            end
            repeat (2) step();
        end
    endtask

    task automatic test_wrap();
        pairsum_t exp;
        for (int i = 0; i < 70; i++) begin
            drive_accept(sample_t'(i * 5 + 3));
            for (int k = 0; k <= int'(PAIRS); k++) begin
                step();
                exp = model_sum(k);
                total++;
                if (bus.oValid !== 1'b1 || bus.oTapIdx !== AW'(k) || bus.oPairSum !== exp) begin
                    bad++;
                    $display("FAIL wrap i=%0d k=%0d: valid=%b idx=%0d sum=%0d want sum=%0d",
                             i, k, bus.oValid, bus.oTapIdx, $signed(bus.oPairSum), exp);
                end
            end
            repeat (2) step();
        end
        total++;
        if (dut.wptr_q !== AW'(n_acc % TAPS)) begin
            bad++;
            $display("FAIL wrap_wptr: got %0d want %0d", dut.wptr_q, n_acc % TAPS);
        end
    endtask

    task automatic test_gated();
        pairsum_t exp;
        bus.iFirIn         = sample_t'(-4);
        bus.iEnDelay       = 1'b0;
        bus.iEnSample_600k = 1'b1;
        step();
        bus.iEnSample_600k = 1'b0;
        for (int c = 0; c < 18; c++) begin
            step();
            total++;
            if (bus.oValid !== 1'b0 || bus.oBusy !== 1'b0) begin
                bad++;
                $display("FAIL gated_quiet c=%0d: valid=%b busy=%b want 0 0", c, bus.oValid, bus.oBusy);
            end
        end
        total++;
        if (dut.wptr_q !== AW'(n_acc % TAPS)) begin
            bad++;
            $display("FAIL gated_wptr: got %0d want %0d", dut.wptr_q, n_acc % TAPS);
        end
        drive_accept(sample_t'(2));
        for (int k = 0; k <= int'(PAIRS); k++) begin
            // a disabled strobe mid-run must neither write nor disturb the sequence
            if (k == 3) begin
                bus.iFirIn         = sample_t'(-4);
                bus.iEnDelay       = 1'b0;
                bus.iEnSample_600k = 1'b1;
            end
            step();
            bus.iEnSample_600k = 1'b0;
            bus.iEnDelay       = 1'b1;
            exp = model_sum(k);
            total++;
            if (bus.oValid !== 1'b1 || bus.oTapIdx !== AW'(k) || bus.oPairSum !== exp) begin
                bad++;
                $display("FAIL gated_seq k=%0d: valid=%b idx=%0d sum=%0d want sum=%0d",
                         k, bus.oValid, bus.oTapIdx, $signed(bus.oPairSum), exp);
            end
        end
        step();
        total++;
        if (bus.oValid !== 1'b0 || bus.oOverrun !== 1'b0) begin
            bad++;
            $display("FAIL gated_end: valid=%b overrun=%b want 0 0", bus.oValid, bus.oOverrun);
        end
        step();
    endtask

    task automatic test_overrun();
        pairsum_t exp;
        // accept lands on the centre beat: no overrun, restart right after
        drive_accept(sample_t'(3));
        for (int k = 0; k < int'(PAIRS); k++) begin
            step();
            exp = model_sum(k);
            total++;
            if (bus.oTapIdx !== AW'(k) || bus.oPairSum !== exp) begin
                bad++;
                $display("FAIL ovr_last_pre k=%0d: idx=%0d sum=%0d want %0d %0d",
                         k, bus.oTapIdx, $signed(bus.oPairSum), k, exp);
            end
        end
        exp = model_sum(int'(PAIRS));
        bus.iFirIn         = sample_t'(-1);
        bus.iEnSample_600k = 1'b1;
        step();
        bus.iEnSample_600k = 1'b0;
        model_push(sample_t'(-1));
        total++;
        if (bus.oTapIdx !== AW'(PAIRS) || bus.oCenter !== 1'b1 || bus.oLast !== 1'b1 ||
            bus.oPairSum !== exp || bus.oOverrun !== 1'b0) begin
            bad++;
            $display("FAIL ovr_last_beat: idx=%0d ctr=%b last=%b sum=%0d ovr=%b want 16 1 1 %0d 0",
                     bus.oTapIdx, bus.oCenter, bus.oLast, $signed(bus.oPairSum), bus.oOverrun, exp);
        end
        for (int k = 0; k <= int'(PAIRS); k++) begin
            step();
            exp = model_sum(k);
            total++;
            if (bus.oValid !== 1'b1 || bus.oTapIdx !== AW'(k) || bus.oPairSum !== exp || bus.oOverrun !== 1'b0) begin
                bad++;
                $display("FAIL ovr_last_restart k=%0d: valid=%b idx=%0d sum=%0d ovr=%b want 1 %0d %0d 0",
                         k, bus.oValid, bus.oTapIdx, $signed(bus.oPairSum), bus.oOverrun, k, exp);
            end
        end
        repeat (2) step();

        // accept carried by the k=5 beat: overrun, restart next clock
        drive_accept(sample_t'(1));
        for (int k = 0; k < 5; k++) step();
        exp = model_sum(5);
        bus.iFirIn         = sample_t'(2);
        bus.iEnSample_600k = 1'b1;
        step();
        bus.iEnSample_600k = 1'b0;
        model_push(sample_t'(2));
        total++;
        if (bus.oTapIdx !== AW'(5) || bus.oPairSum !== exp || bus.oOverrun !== 1'b1) begin
            bad++;
            $display("FAIL ovr_mid_beat: idx=%0d sum=%0d ovr=%b want 5 %0d 1",
                     bus.oTapIdx, $signed(bus.oPairSum), bus.oOverrun, exp);
        end
        for (int k = 0; k <= int'(PAIRS); k++) begin
            step();
            exp = model_sum(k);
            total++;
            if (bus.oValid !== 1'b1 || bus.oTapIdx !== AW'(k) || bus.oPairSum !== exp) begin
                bad++;
                $display("FAIL ovr_mid_restart k=%0d: valid=%b idx=%0d sum=%0d want 1 %0d %0d",
                         k, bus.oValid, bus.oTapIdx, $signed(bus.oPairSum), k, exp);
            end
        end
        repeat (2) step();
        total++;
        if (bus.oOverrun !== 1'b1 || bus.oValid !== 1'b0) begin
            bad++;
            $display("FAIL ovr_sticky: ovr=%b valid=%b want 1 0", bus.oOverrun, bus.oValid);
        end
    endtask

    task automatic test_reset_mid();
        pairsum_t exp;
        drive_accept(sample_t'(2));
        for (int k = 0; k <= 8; k++) step();
        total++;
        if (bus.oTapIdx !== AW'(8) || bus.oBusy !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_pre: idx=%0d busy=%b want 8 1", bus.oTapIdx, bus.oBusy);
        end
        #3 iRsn = 1'b0;
        #2;
        total++;
        if ({bus.oValid, bus.oLast, bus.oCenter, bus.oBusy, bus.oOverrun, bus.oTapIdx, bus.oPairSum} !== 15'd0) begin
            bad++;
            $display("FAIL rstmid_async: got %b want all zero",
                     {bus.oValid, bus.oLast, bus.oCenter, bus.oBusy, bus.oOverrun, bus.oTapIdx, bus.oPairSum});
        end
        repeat (2) step();
        #4 iRsn = 1'b1;
        model_clear();
        step();
        total++;
        if (bus.oValid !== 1'b0 || bus.oBusy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_release: valid=%b busy=%b want 0 0", bus.oValid, bus.oBusy);
        end
        drive_accept(sample_t'(3));
        for (int k = 0; k <= int'(PAIRS); k++) begin
            step();
            exp = (k == 0) ? pairsum_t'(3) : pairsum_t'(0);
            total++;
            if (bus.oValid !== 1'b1 || bus.oTapIdx !== AW'(k) || bus.oPairSum !== exp) begin
                bad++;
                $display("FAIL rstmid_seq k=%0d: valid=%b idx=%0d sum=%0d want 1 %0d %0d",
                         k, bus.oValid, bus.oTapIdx, $signed(bus.oPairSum), k, exp);
            end
        end
        step();
        total++;
        if (bus.oValid !== 1'b0 || dut.wptr_q !== AW'(1)) begin
            bad++;
            $display("FAIL rstmid_end: valid=%b wptr=%0d want 0 1", bus.oValid, dut.wptr_q);
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_ramp();
        test_wrap();
        test_gated();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
